// File: rtl/mac_operand_fetcher_if.sv
// mac_operand_fetcher_if: control + operand-memory bundle.
// master = control unit / memory side, slave = fetcher.
//   start, base_addr, pair_count : run request
//   mem_address, mem_enable      : memory read port
//   first/second_operand         : memory read data
//   busy, done, acc_out,
//   pair_index, overflow         : run status / result
interface mac_operand_fetcher_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        pair_count;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_enable;
  logic [DATA_W-1:0] first_operand;
  logic [DATA_W-1:0] second_operand;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  acc_out;
  logic [7:0]        pair_index;
  logic              overflow;

  modport master (
    output start, base_addr, pair_count,
    output first_operand, second_operand,
    input  mem_address, mem_enable,
    input  busy, done, acc_out,
    input  pair_index, overflow
  );

  modport slave (
    input  start, base_addr, pair_count,
    input  first_operand, second_operand,
    output mem_address, mem_enable,
    output busy, done, acc_out,
    output pair_index, overflow
  );
endinterface

// File: rtl/mac_operand_fetcher.sv
// mac_operand_fetcher: walks operand memory in 8-byte
// strides and accumulates unsigned first*second products.
//   clk, reset (async, active-high)
//   bus.slave : start/base_addr/pair_count in,
//               mem_address/mem_enable out,
//               first/second_operand in,
//               busy/done/acc_out/pair_index/overflow out
module mac_operand_fetcher #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 64,
  parameter int MEM_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  mac_operand_fetcher_if.slave bus
);
  localparam int CNT_W =
    (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE,
    S_WAIT, S_ACCUM, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_count;
  logic [7:0]        r_idx;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic              r_busy;
  logic              r_done;

  logic [7:0]        w_idx_inc;
  logic [7:0]        w_iss_idx;
  logic [ADDR_W-1:0] w_iss_addr;
  logic [PW-1:0]     w_prod;
  logic [ACC_W:0]    w_sum;
  logic              w_lat_done;

  assign w_idx_inc  = r_idx + 8'd1;
  assign w_lat_done = (r_cnt == CNT_W'(MEM_LAT - 1));

  // Leaving ACCUM the index increments on the same
  // edge, so the next address uses the bumped value.
  assign w_iss_idx  = (r_state == S_ACCUM) ?
                      w_idx_inc : r_idx;
  assign w_iss_addr = r_base +
                      (ADDR_W'(w_iss_idx) << 3);

  assign w_prod = PW'(bus.first_operand) *
                  PW'(bus.second_operand);
  assign w_sum  = {1'b0, r_acc} +
                  {1'b0, ACC_W'(w_prod)};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start)
          w_next = (bus.pair_count == 8'd0) ?
                   S_DONE : S_ARM;
      S_ARM:   w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:
        if (w_lat_done) w_next = S_ACCUM;
      S_ACCUM:
        w_next = (w_idx_inc == r_count) ?
                 S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '1;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_en    <= (w_next == S_ARM)   ||
                 (w_next == S_ISSUE) ||
                 (w_next == S_WAIT)  ||
                 (w_next == S_ACCUM);
      if (w_next == S_ISSUE)
        r_addr <= w_iss_addr;
      else if (w_next == S_IDLE ||
               w_next == S_ARM  ||
               w_next == S_DONE)
        r_addr <= '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_base  <= bus.base_addr;
        r_count <= bus.pair_count;
        r_idx   <= '0;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_ACCUM) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
        r_idx <= w_idx_inc;
      end
    end
  end

  assign bus.mem_address = r_addr;
  assign bus.mem_enable  = r_en;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.acc_out     = r_acc;
  assign bus.pair_index  = r_idx;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_mac_operand_fetcher.sv
// tb_mac_operand_fetcher: scoreboard bench for the
// operand fetcher with a registered memory model.
module tb_mac_operand_fetcher;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;
  localparam int LAT    = 1;
  localparam int PER    = 2 + LAT;
  localparam logic [ADDR_W-1:0] PARK = '1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_operand_fetcher_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)
  ) bif ();

  mac_operand_fetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .MEM_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_mode = 0;
  bit saw_en   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Word at 8i = i+1, at 8i+4 = i+2; mode 1 = all ones.
  function automatic logic [DATA_W-1:0] mem_word(
    input logic [ADDR_W-1:0] a);
    if (mem_mode == 1) return '1;
    return DATA_W'(a >> 3) + (a[2] ? 32'd2 : 32'd1);
  endfunction

  always @(posedge clk) begin
    if (bif.mem_enable) begin
      bif.first_operand  <= mem_word(bif.mem_address);
      bif.second_operand <=
        mem_word(bif.mem_address + ADDR_W'(4));
    end else begin
      bif.first_operand  <= 32'hDEADBEEF;
      bif.second_operand <= 32'hBADC0FFE;
    end
  end

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [7:0]       idx;
    logic             ovf;
    int               cyc;
  } res_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                cyc;
  } iss_t;

  res_t res_q[$];
  iss_t iss_q[$];
  logic [ADDR_W-1:0] prev_addr = '1;

  always @(negedge clk) begin
    iss_t e;
    res_t r;
    if (bif.mem_enable === 1'b1) saw_en = 1;
    if (!reset && bif.mem_address !== prev_addr &&
        bif.mem_address !== PARK) begin
      n_checks++;
      if (iss_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: addr %h cyc %0d, required no issue",
                 bif.mem_address, cyc);
      end else begin
        e = iss_q.pop_front();
        if (bif.mem_address !== e.addr || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL issue_addr: got %h @%0d, required %h @%0d",
                   bif.mem_address, cyc, e.addr, e.cyc);
        end
      end
    end
    prev_addr = bif.mem_address;
    if (bif.done === 1'b1) begin
      n_checks++;
      if (res_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done at cyc %0d, required none",
                 cyc);
      end else begin
        r = res_q.pop_front();
        if (bif.acc_out !== r.acc ||
            bif.pair_index !== r.idx ||
            bif.overflow !== r.ovf || cyc != r.cyc) begin
          n_fail++;
          $display("FAIL done_result: acc %h idx %0d ovf %b @%0d, required acc %h idx %0d ovf %b @%0d",
                   bif.acc_out, bif.pair_index, bif.overflow,
                   cyc, r.acc, r.idx, r.ovf, r.cyc);
        end
      end
    end
  end

  // Drives one start; pushes expected issues and result.
  task automatic do_start(
    input  logic [ADDR_W-1:0] base,
    input  logic [7:0]        n,
    output int                t0);
    res_t r;
    logic [ACC_W:0]    s;
    logic [2*DATA_W-1:0] p;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    bif.start      = 1'b1;
    bif.base_addr  = base;
    bif.pair_count = n;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    bif.start = 1'b0;
    r.acc = '0;
    r.ovf = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      a = base + ADDR_W'(8 * k);
      iss_q.push_back('{a, t0 + 2 + PER * k});
      p = (2*DATA_W)'(mem_word(a)) *
          (2*DATA_W)'(mem_word(a + ADDR_W'(4)));
      s = {1'b0, r.acc} + (ACC_W+1)'(p);
      r.acc = s[ACC_W-1:0];
      r.ovf = r.ovf | s[ACC_W];
    end
    r.idx = n;
    r.cyc = (n == 0) ? t0 + 1 : t0 + 2 + PER * int'(n);
    res_q.push_back(r);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((res_q.size() != 0 || bif.busy !== 1'b0)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200 || iss_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: waited %0d, pending res %0d iss %0d, required 0",
               name, n, res_q.size(), iss_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.mem_address !== 21'h1FFFFF) begin
      n_fail++;
      $display("FAIL rst_addr: %h, required 1fffff",
               bif.mem_address);
    end
    n_checks++;
    if (bif.mem_enable !== 1'b0 || bif.busy !== 1'b0 ||
        bif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl: en %b busy %b done %b, required 000",
               bif.mem_enable, bif.busy, bif.done);
    end
    n_checks++;
    if (bif.acc_out !== '0 || bif.overflow !== 1'b0 ||
        bif.pair_index !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_acc: acc %h ovf %b idx %0d, required 0",
               bif.acc_out, bif.overflow, bif.pair_index);
    end
  endtask

  task automatic test_basic();
    int t0;
    mem_mode = 0;
    do_start(21'h0, 8'd3, t0);
    n_checks++;
    if (bif.mem_enable !== 1'b1 || bif.busy !== 1'b1 ||
        bif.mem_address !== PARK) begin
      n_fail++;
      $display("FAIL arm_state: en %b busy %b addr %h, required 1 1 %h",
               bif.mem_enable, bif.busy, bif.mem_address, PARK);
    end
    wait_drain("basic");
    n_checks++;
    if (bif.acc_out !== 64'd20 || bif.pair_index !== 8'd3 ||
        bif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: acc %0d idx %0d ovf %b, required 20 3 0",
               bif.acc_out, bif.pair_index, bif.overflow);
    end
  endtask

  task automatic test_zero_count();
    int t0;
    saw_en = 0;
    do_start(21'h40, 8'd0, t0);
    n_checks++;
    if (bif.done !== 1'b1 || bif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done %b busy %b, required 1 1",
               bif.done, bif.busy);
    end
    wait_drain("zero");
    n_checks++;
    if (saw_en !== 1'b0 || bif.acc_out !== '0 ||
        bif.pair_index !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_quiet: saw_en %b acc %h idx %0d, required 0 0 0",
               saw_en, bif.acc_out, bif.pair_index);
    end
  endtask

  task automatic test_overflow();
    int t0;
    mem_mode = 1;
    do_start(21'h0, 8'd2, t0);
    wait_drain("ovf");
    n_checks++;
    if (bif.acc_out !== 64'hFFFFFFFC00000002 ||
        bif.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_result: acc %h ovf %b, required fffffffc00000002 1",
               bif.acc_out, bif.overflow);
    end
    mem_mode = 0;
    do_start(21'h18, 8'd1, t0);
    n_checks++;
    if (bif.overflow !== 1'b0 || bif.acc_out !== '0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf %b acc %h, required 0 0",
               bif.overflow, bif.acc_out);
    end
    wait_drain("ovf_clr");
  endtask

  task automatic test_start_busy();
    int t0;
    bit extra = 0;
    mem_mode = 0;
    do_start(21'h0, 8'd3, t0);
    while (cyc < t0 + 4) @(negedge clk);
    bif.start      = 1'b1;
    bif.base_addr  = 21'h100;
    bif.pair_count = 8'd5;
    @(negedge clk);
    bif.start = 1'b0;
    while (cyc < t0 + 11) @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    n_checks++;
    if (bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_idle_gap: busy %b, required 0",
               bif.busy);
    end
    repeat (10) begin
      @(negedge clk);
      if (bif.busy !== 1'b0) extra = 1;
    end
    n_checks++;
    if (extra) begin
      n_fail++;
      $display("FAIL busy_second_run: busy seen 1, required 0");
    end
    wait_drain("busy");
  endtask

  task automatic test_reset_midrun();
    int t0;
    mem_mode = 0;
    do_start(21'h0, 8'd3, t0);
    while (cyc < t0 + 6) @(negedge clk);
    n_checks++;
    if (bif.mem_address !== 21'h8 ||
        bif.mem_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait: addr %h en %b, required 8 1",
               bif.mem_address, bif.mem_enable);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bif.mem_address !== PARK || bif.mem_enable !== 1'b0 ||
        bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctrl: addr %h en %b busy %b done %b, required park 0 0 0",
               bif.mem_address, bif.mem_enable,
               bif.busy, bif.done);
    end
    n_checks++;
    if (bif.acc_out !== '0 || bif.pair_index !== 8'd0 ||
        bif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_acc: acc %h idx %0d ovf %b, required 0",
               bif.acc_out, bif.pair_index, bif.overflow);
    end
    iss_q.delete();
    res_q.delete();
    @(negedge clk);
    reset = 1'b0;
    do_start(21'h0, 8'd3, t0);
    wait_drain("mid_rerun");
    n_checks++;
    if (bif.acc_out !== 64'd20) begin
      n_fail++;
      $display("FAIL mid_rerun_acc: %0d, required 20",
               bif.acc_out);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bif.start      = 1'b0;
    bif.base_addr  = '0;
    bif.pair_count = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_start_busy();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_operand_fetcher.md
# mac_operand_fetcher

Sequencer that drives the instruction/operand memory's read port on behalf of the MAC datapath. Given a base byte address and a pair count, it walks the memory in 8-byte strides, samples each first/second operand pair after a fixed memory settle time, and accumulates the unsigned products. It sits between the control unit, which issues `start`, and the operand memory, whose `address` and `stop_signal` inputs it owns.

## Interface
- `ADDR_W`, default 21: memory address width.
- `DATA_W`, default 32: operand width.
- `ACC_W`, default 64: accumulator width.
- `MEM_LAT`, default 1: cycles to wait after an address change before sampling operands (≥1).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `base_addr`  in  ADDR_W  byte address of first operand pair; sampled with `start`.
- `pair_count`  in  8  number of pairs to process; sampled with `start`.
- `mem_address`  out  ADDR_W  drives memory `address`.
- `mem_enable`  out  1  drives memory `stop_signal`; 1 = memory returns data.
- `first_operand`  in  DATA_W  from memory, bytes [a..a+3].
- `second_operand`  in  DATA_W  from memory, bytes [a+4..a+7].
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at run completion.
- `acc_out`  out  ACC_W  running/final accumulator.
- `pair_index`  out  8  pairs accumulated so far in the current run.
- `overflow`  out  1  sticky; accumulator carried out of ACC_W during the run.

## Operation
- States: IDLE, ARM, ISSUE, WAIT, ACCUM, DONE.
- IDLE: `mem_enable`=0, `mem_address`=all-ones (park value, so every real address is a change seen by the memory). On `start`: latch `base_addr` and `pair_count`; clear `acc_out`, `pair_index`, and `overflow`. Go to DONE if `pair_count`=0, else to ARM.
- ARM (1 cycle): `mem_enable`=1, address still parked. The enable must be stable before the first address change.
- ISSUE (1 cycle): `mem_address` = base + 8·`pair_index`; go to WAIT.
- WAIT: a counter runs `MEM_LAT` cycles, then the FSM goes to ACCUM.
- ACCUM (1 cycle): `acc_out` += `first_operand` × `second_operand`.
  - Both operands are unsigned; the product is 2·DATA_W bits, zero-extended or truncated to ACC_W.
  - Sum is taken modulo 2^ACC_W. A carry out sets `overflow`.
  - `pair_index`++. If `pair_index`+1 = `pair_count`, go to DONE, else to ISSUE.
- DONE (1 cycle): `done`=1, `mem_enable`=0, address parked; go to IDLE. `acc_out`, `pair_index`, and `overflow` hold until the next `start`.
- Address arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W. The fetcher applies no 7-bit masking; the memory does its own.
- `start` while `busy` is ignored, and the latched parameters are unaffected.
- `reset` at any time, mid-run included, forces IDLE and aborts the run:
  - `mem_enable`=0, `mem_address`=all-ones.
  - `busy`=0, `done`=0.
  - `acc_out`=0, `pair_index`=0, `overflow`=0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Per pair: ISSUE + `MEM_LAT` WAIT + ACCUM = 2+`MEM_LAT` cycles.
- Let `start` be sampled at edge t0:
  - ARM at t0+1.
  - First ISSUE at t0+2.
  - `done` is high during cycle t0+2+N·(2+`MEM_LAT`).
- `pair_count`=0: `done` high in cycle t0+1, with no `mem_enable` assertion and no address change.
- `busy` rises at t0+1 and falls in the cycle after DONE.
- A new `start` is accepted in the first IDLE cycle after DONE. Back-to-back runs are separated by exactly that one IDLE cycle.
- Operands are sampled only at the ACCUM edge. Values present in ISSUE or WAIT are ignored.

## Test plan
- Reset state: after reset, check `mem_address`=21'h1FFFFF, `mem_enable`=0, `busy`=0, `done`=0, `acc_out`=0, `overflow`=0.
- Basic run, `MEM_LAT`=1:
  - Setup: memory model word at 8i = i+1 and at 8i+4 = i+2; `base_addr`=0, `pair_count`=3, `start` at t0.
  - Addresses: 0, 8, 16 issued at t0+2, t0+5, t0+8.
  - Result: `done` at t0+11, `acc_out`=20, `pair_index`=3, `overflow`=0.
- Zero count: `pair_count`=0 → `done` at t0+1, `acc_out`=0, `mem_enable` never 1.
- Overflow: with ACC_W=64, both operands 32'hFFFFFFFF, 2 pairs.
  - Product per pair = 64'hFFFFFFFE00000001.
  - Final `acc_out` = 64'hFFFFFFFC00000002 mod 2^64, `overflow`=1.
  - `overflow` clears on the next `start`.
- Start while busy: pulse `start` with a new base mid-run. The run completes with the original addresses and result, and no second run begins.
- Reset mid-run: assert `reset` during the second WAIT of a 3-pair run. All outputs return to reset values immediately. The next `start` runs cleanly with the expected sum.
